// File: rtl/gcd_arb.sv
`default_nettype none
// ============================================================================
// Module      : gcd_arb
// Description : Round-robin arbiter for NREQ requesters sharing one GCD engine,
//               with zero-operand bypass and a done-wait timeout.
// Revision    : 1.0
// ============================================================================
module gcd_arb #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_opa,
    input  logic [NREQ*WIDTH-1:0]   req_opb,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_err,
    output logic [WIDTH-1:0]        gcd_opa,
    output logic [WIDTH-1:0]        gcd_opb,
    output logic                    gcd_start,
    input  logic [WIDTH-1:0]        gcd_result,
    input  logic                    gcd_done,
    output logic                    busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] C_CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] C_LAST_RESET = GW'(NREQ - 1);
    localparam logic [GW:0]   C_NREQ       = (GW + 1)'(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic [GW:0]       cand;
    logic [WIDTH-1:0]  sel_opa;
    logic [WIDTH-1:0]  sel_opb;
    logic              accept;

    // Search starts just after the last served requester so nobody starves.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_q} + (GW + 1)'(k);
            if (cand >= C_NREQ) begin
                cand = cand - C_NREQ;
            end
            if (!pick_found && req_valid[cand[GW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[GW-1:0];
            end
        end
    end

    assign accept  = (state_q == S_IDLE) && pick_found;
    assign sel_opa = req_opa[int'(pick_idx) * WIDTH +: WIDTH];
    assign sel_opb = req_opb[int'(pick_idx) * WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (accept && rst_n) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        result_d     = result_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d = pick_idx;
                    opa_d   = sel_opa;
                    opb_d   = sel_opb;
                    if ((sel_opa == '0) || (sel_opb == '0)) begin
                        // gcd(x,0) = x, so the engine is skipped entirely.
                        result_d = sel_opa | sel_opb;
                        err_d    = 1'b0;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (gcd_done) begin
                    result_d = gcd_result;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= C_LAST_RESET;
            opa_q        <= '0;
            opb_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            result_q     <= result_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign gcd_start  = (state_q == S_START);
    assign busy       = (state_q != S_IDLE);
    assign gcd_opa    = ((state_q == S_START) || (state_q == S_WAIT)) ? opa_q : '0;
    assign gcd_opb    = ((state_q == S_START) || (state_q == S_WAIT)) ? opb_q : '0;
    assign rsp_result = (state_q == S_RESP) ? result_q : '0;
    assign rsp_err    = (state_q == S_RESP) && err_q;

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

endmodule
`default_nettype wire
